// File: rtl/sha_miner_pkg.sv
// Shared widths and sequencer state encoding for the SHA nonce search logic.
package sha_miner_pkg;

  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 256;
  localparam int MSG_W    = 512;
  localparam int PREFIX_W = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_CHECK
  } seq_state_e;

endpackage

// File: rtl/hash_less_than.sv
// Combinational unsigned 256-bit comparator: lt is high when a < b.
module hash_less_than
  import sha_miner_pkg::*;
(
  input  logic [HASH_W-1:0] a,
  input  logic [HASH_W-1:0] b,
  output logic              lt
);

  assign lt = (a < b);

endmodule

// File: rtl/sha_nonce_sequencer.sv
// Walks a nonce range through the SHA block and stops on the first digest below target.
// Build macro SHA_TIMEOUT_EN adds a per-attempt COMPUTE watchdog driving timeoutErr.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result flags hold
// LOAD    | one-cycle begin pulse to the SHA block
// COMPUTE | SHA enabled; completion accepted from the second cycle on
// CHECK   | compare captured digest, then finish or advance the nonce
module sha_nonce_sequencer
  import sha_miner_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] msgPrefix,
  input  logic [NONCE_W-1:0]  nonceStart,
  input  logic [NONCE_W-1:0]  nonceEnd,
  input  logic [HASH_W-1:0]   target,
  output logic [MSG_W-1:0]    inputSHAMsg,
  output logic                beginComputation,
  output logic                enableComputation,
  input  logic                computationComplete,
  input  logic [HASH_W-1:0]   shaOutput,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [NONCE_W-1:0]  foundNonce,
  output logic [HASH_W-1:0]   foundHash,
  output logic                timeoutErr
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_e            state_q;
  logic [PREFIX_W-1:0]   prefix_q;
  logic [HASH_W-1:0]     target_q;
  logic [HASH_W-1:0]     hash_q;
  logic [NONCE_W-1:0]    nonce_q;
  logic [NONCE_W-1:0]    nonce_end_q;
  logic                  first_q;
  logic                  hit;

`ifdef SHA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;
  assign timeoutErr = tmo_err_q;
`else
  assign timeoutErr = 1'b0;
`endif

  hash_less_than u_cmp (
    .a  (hash_q),
    .b  (target_q),
    .lt (hit)
  );

  assign inputSHAMsg       = {prefix_q, nonce_q};
  assign beginComputation  = (state_q == ST_LOAD);
  assign enableComputation = (state_q == ST_LOAD) || (state_q == ST_COMPUTE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      prefix_q    <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      first_q     <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      foundNonce  <= '0;
      foundHash   <= '0;
`ifdef SHA_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            prefix_q    <= msgPrefix;
            target_q    <= target;
            nonce_end_q <= nonceEnd;
            nonce_q     <= nonceStart;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            foundNonce  <= '0;
            foundHash   <= '0;
            busy        <= 1'b1;
`ifdef SHA_TIMEOUT_EN
            tmo_err_q   <= 1'b0;
`endif
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          first_q <= 1'b1;
`ifdef SHA_TIMEOUT_EN
          tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          state_q <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          first_q <= 1'b0;
          // A completion level still high from the previous attempt is ignored on entry.
          if (computationComplete && !first_q) begin
            hash_q  <= shaOutput;
            state_q <= ST_CHECK;
          end
`ifdef SHA_TIMEOUT_EN
          else if (tmo_cnt_q == '0) begin
            tmo_err_q <= 1'b1;
            busy      <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
          end
`endif
        end
        ST_CHECK: begin
          if (hit) begin
            found      <= 1'b1;
            foundNonce <= nonce_q;
            foundHash  <= hash_q;
            busy       <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (nonce_q == nonce_end_q) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            nonce_q <= nonce_q + 1'b1;
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Abort overrides whatever the active state decided this cycle.
      if (abort && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        busy      <= 1'b0;
        found     <= 1'b0;
        exhausted <= 1'b0;
`ifdef SHA_TIMEOUT_EN
        tmo_err_q <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Directed bench for sha_nonce_sequencer with a SHA stub returning {~nonce, 224'h0}.
// Honours SHA_TIMEOUT_EN the same way as the design.
module tb_sha_nonce_sequencer;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [479:0] msgPrefix = '0;
  logic [31:0]  nonceStart = '0;
  logic [31:0]  nonceEnd = '0;
  logic [255:0] target = '0;
  logic [511:0] inputSHAMsg;
  logic         beginComputation;
  logic         enableComputation;
  logic         computationComplete = 1'b0;
  logic [255:0] shaOutput;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  foundNonce;
  logic [255:0] foundHash;
  logic         timeoutErr;

  int n_checks = 0;
  int n_pass   = 0;

  // 0: complete 64 cycles after begin, 1: never complete, 2: complete held high always
  int          stub_mode = 0;
  int          stub_cnt = 0;
  logic [31:0] stub_nonce = '0;
  int          begin_cnt = 0;

  sha_nonce_sequencer dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .start               (start),
    .abort               (abort),
    .msgPrefix           (msgPrefix),
    .nonceStart          (nonceStart),
    .nonceEnd            (nonceEnd),
    .target              (target),
    .inputSHAMsg         (inputSHAMsg),
    .beginComputation    (beginComputation),
    .enableComputation   (enableComputation),
    .computationComplete (computationComplete),
    .shaOutput           (shaOutput),
    .busy                (busy),
    .found               (found),
    .exhausted           (exhausted),
    .foundNonce          (foundNonce),
    .foundHash           (foundHash),
    .timeoutErr          (timeoutErr)
  );

  always #5 clk = ~clk;

  assign shaOutput = {~stub_nonce, 224'h0};

  always @(posedge clk) begin
    if (stub_mode == 2) computationComplete <= 1'b1;
    else if (beginComputation) computationComplete <= 1'b0;
    else if (stub_mode == 0 && stub_cnt == 1) computationComplete <= 1'b1;
    if (beginComputation) begin
      stub_cnt   <= 64;
      stub_nonce <= inputSHAMsg[31:0];
      begin_cnt  <= begin_cnt + 1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulse start for one edge; returns at the negedge of the LOAD cycle.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output bit ok, output bit check_then_idle);
    bit was_check = 1'b0;
    ok = 1'b0;
    check_then_idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        check_then_idle = was_check;
        break;
      end
      was_check = busy && !enableComputation;
      step();
    end
  endtask

  initial begin
    bit ok, cti;
    int base, ncomp;

    // Reset
    step(2);
    check("rst_msg", inputSHAMsg, '0);
    check("rst_begin", beginComputation, 0);
    check("rst_enable", enableComputation, 0);
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_exh", exhausted, 0);
    check("rst_fnonce", foundNonce, 0);
    check("rst_fhash", foundHash, 0);
    check("rst_tmo", timeoutErr, 0);
    n_rst = 1'b1;
    step(2);

    // Single attempt, hit on nonce 3
    msgPrefix  = {15{32'hA5A5_0001}};
    nonceStart = 32'd3;
    nonceEnd   = 32'd3;
    target     = {32'hFFFF_FFFD, 224'h0};
    base = begin_cnt;
    pulse_start();
    check("s1_busy_n1", busy, 1);
    check("s1_begin_n1", beginComputation, 1);
    check("s1_msg", inputSHAMsg, {{15{32'hA5A5_0001}}, 32'd3});
    run_to_done(500, ok, cti);
    check("s1_done", ok, 1);
    check("s1_begins", begin_cnt - base, 1);
    check("s1_found", found, 1);
    check("s1_exh", exhausted, 0);
    check("s1_fnonce", foundNonce, 32'd3);
    check("s1_fhash", foundHash, {32'hFFFF_FFFC, 224'h0});
    step(5);
    check("s1_found_hold", found, 1);

    // Range 0x0C..0x20, first hit at 0x10
    nonceStart = 32'h0C;
    nonceEnd   = 32'h20;
    target     = {32'hFFFF_FFF0, 224'h0};
    base = begin_cnt;
    pulse_start();
    check("s2_found_clr", found, 0);
    run_to_done(2000, ok, cti);
    check("s2_done", ok, 1);
    check("s2_busy_after_check", cti, 1);
    check("s2_begins", begin_cnt - base, 5);
    check("s2_found", found, 1);
    check("s2_fnonce", foundNonce, 32'h10);
    check("s2_fhash", foundHash, {32'hFFFF_FFEF, 224'h0});

    // Wrapping range, target 0 never hits
    nonceStart = 32'hFFFF_FFFE;
    nonceEnd   = 32'h1;
    target     = '0;
    base = begin_cnt;
    pulse_start();
    run_to_done(2000, ok, cti);
    check("s3_done", ok, 1);
    check("s3_begins", begin_cnt - base, 4);
    check("s3_exh", exhausted, 1);
    check("s3_found", found, 0);
    check("s3_fnonce", foundNonce, 0);
    check("s3_last_nonce", inputSHAMsg[31:0], 32'h1);

    // Stale completion level: first COMPUTE cycle must not accept it
    stub_mode = 2;
    step(2);
    nonceStart = 32'd5;
    nonceEnd   = 32'd5;
    pulse_start();
    check("s4_load", beginComputation, 1);
    ncomp = 0;
    step();
    while (enableComputation && !beginComputation && ncomp < 10) begin
      ncomp++;
      step();
    end
    check("s4_compute_cycles", ncomp, 2);
    run_to_done(20, ok, cti);
    check("s4_done", ok, 1);
    check("s4_exh", exhausted, 1);
    stub_mode = 0;

    // Abort in COMPUTE cycle 10; start while busy is ignored
    nonceStart = 32'd0;
    nonceEnd   = 32'd100;
    target     = '0;
    pulse_start();
    step(5);
    start = 1'b1;
    nonceStart = 32'h55;
    step();
    start = 1'b0;
    check("s5_start_ignored", inputSHAMsg[31:0], 32'd0);
    check("s5_no_reload", beginComputation, 0);
    step(4);
    check("s5_in_compute", enableComputation && !beginComputation, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s5_abort_busy", busy, 0);
    check("s5_abort_enable", enableComputation, 0);
    check("s5_abort_begin", beginComputation, 0);
    check("s5_abort_found", found, 0);
    check("s5_abort_exh", exhausted, 0);

    // Abort and start together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("s6_abort_wins_busy", busy, 0);
    check("s6_abort_wins_begin", beginComputation, 0);

    // SHA never completes
    stub_mode  = 1;
    nonceStart = 32'd7;
    nonceEnd   = 32'd7;
    pulse_start();
`ifdef SHA_TIMEOUT_EN
    ncomp = 0;
    step();
    while (busy && ncomp < 300) begin
      if (enableComputation && !beginComputation) ncomp++;
      step();
    end
    check("s7_tmo_cycles", ncomp, 100);
    check("s7_tmo_err", timeoutErr, 1);
    check("s7_tmo_busy", busy, 0);
    check("s7_tmo_found", found, 0);
    check("s7_tmo_exh", exhausted, 0);
`else
    step(1000);
    check("s7_still_busy", busy, 1);
    check("s7_still_enable", enableComputation, 1);
    check("s7_no_tmo", timeoutErr, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s7_abort_busy", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
